// File: rtl/microwave_ctrl.sv
// Microwave cook-timer sequencer: latches a cook time, counts it down on a
// prescaled tick, drives the magnetron enable and sounds an end-of-cook beep.
module microwave_ctrl #(
    parameter int TW       = 4,
    parameter int TICK_DIV = 4,
    parameter int BEEP_LEN = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] tin,
    input  logic          load,
    input  logic          start,
    input  logic          stop,
    input  logic          door,
    output logic          p,
    output logic [TW-1:0] remain,
    output logic          done,
    output logic [1:0]    st
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BEEP_LEN > 0) ? $clog2(BEEP_LEN + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_INIT = BW'(BEEP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] remain_n;
    logic [PW-1:0] presc, presc_n;
    logic [BW-1:0] beep, beep_n;
    logic          done_n;

    // NOTE: every next-value signal gets a hold default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        remain_n = remain;
        presc_n  = presc;
        beep_n   = beep;
        done_n   = done;
        case (state)
            S_IDLE: begin
                if (load) begin
                    remain_n = tin;
                end else if (start && !door && remain != '0) begin
                    state_n = S_RUN;
                    presc_n = '0;
                end
            end
            S_RUN: begin
                // A pause request beats a same-cycle tick wrap.
                if (door || stop) begin
                    state_n = S_PAUSE;
                end else if (presc == PRESC_MAX) begin
                    presc_n = '0;
                    if (remain != '0) begin
                        remain_n = remain - TW'(1);
                    end
                    if (remain == TW'(1)) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        beep_n  = BEEP_INIT;
                    end
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_n  = S_IDLE;
                    remain_n = '0;
                    presc_n  = '0;
                end else if (start && !door) begin
                    state_n = S_RUN;
                end
            end
            S_DONE: begin
                remain_n = '0;
                if (stop || beep == '0) begin
                    state_n = S_IDLE;
                    done_n  = 1'b0;
                end else begin
                    beep_n = beep - BW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            remain <= '0;
            presc  <= '0;
            beep   <= '0;
            done   <= 1'b0;
            p      <= 1'b0;
        end else begin
            state  <= state_n;
            remain <= remain_n;
            presc  <= presc_n;
            beep   <= beep_n;
            done   <= done_n;
            p      <= (state_n == S_RUN);
        end
    end

    assign st = state;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed scenarios followed by
// randomized front-panel activity, compared against a cook-time model.
module tb_microwave_ctrl;

    localparam int TW       = 4;
    localparam int TICK_DIV = 4;
    localparam int BEEP_LEN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [TW-1:0] tin = '0;
    logic          load = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          door = 1'b0;
    logic          p;
    logic [TW-1:0] remain;
    logic          done;
    logic [1:0]    st;

    microwave_ctrl #(.TW(TW), .TICK_DIV(TICK_DIV), .BEEP_LEN(BEEP_LEN)) dut (
        .clk(clk), .rst(rst), .tin(tin), .load(load), .start(start),
        .stop(stop), .door(door), .p(p), .remain(remain), .done(done), .st(st)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    passed = 0;
    int    fails = 0;
    int    cook_cnt = 0;
    string phase = "reset";

    // Model: st codes 0 idle, 1 cooking, 2 paused, 3 beeping. Remaining time
    // is derived from the loaded time and the clock cycles spent cooking.
    int m_st = 0;
    int m_loaded = 0;
    int m_cooked = 0;
    int m_beep = 0;

    function automatic int m_remain();
        return m_loaded - m_cooked / TICK_DIV;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s/%s: observed %0d, expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (!rst) begin
            m_st = 0; m_loaded = 0; m_cooked = 0; m_beep = 0;
            return;
        end
        case (m_st)
            0: begin
                if (load) begin
                    m_loaded = int'(tin);
                    m_cooked = 0;
                end else if (start && !door && m_remain() != 0) begin
                    m_st = 1;
                    m_cooked = 0;
                end
            end
            1: begin
                if (door || stop) m_st = 2;
                else begin
                    m_cooked++;
                    if (m_remain() == 0) begin
                        m_st = 3; m_beep = BEEP_LEN; m_loaded = 0; m_cooked = 0;
                    end
                end
            end
            2: begin
                if (stop) begin
                    m_st = 0; m_loaded = 0; m_cooked = 0;
                end else if (start && !door) m_st = 1;
            end
            default: begin
                if (stop) m_st = 0;
                else begin
                    m_beep--;
                    if (m_beep == 0) m_st = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check("st", 32'(st), 32'(m_st));
        check("p", 32'(p), 32'(m_st == 1));
        check("remain", 32'(remain), 32'(m_remain()));
        check("done", 32'(done), 32'(m_st == 3));
    endtask

    // One clock: drive inputs, take the edge, update the model, check #1 later.
    task automatic cyc(input logic r, input logic l, input logic s, input logic sp,
                       input logic d, input logic [TW-1:0] t);
        rst = r; load = l; start = s; stop = sp; door = d; tin = t;
        if (r && p && !d && !sp) cook_cnt++;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Full cook of 3 ticks
        phase = "full_cook";
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("p_after_start", 32'(p), 32'd1);
        cook_cnt = 0;
        idle(4);  check("remain_4th", 32'(remain), 32'd2);
        idle(4);  check("remain_8th", 32'(remain), 32'd1);
        idle(4);  check("remain_12th", 32'(remain), 32'd0);
        check("st_done", 32'(st), 32'd3);
        check("p_off_done", 32'(p), 32'd0);
        check("cook_cycles", 32'(cook_cnt), 32'd12);
        idle(2);  check("done_3rd", 32'(done), 32'd1);
        idle(1);  check("st_idle_after_beep", 32'(st), 32'd0);
        check("done_off", 32'(done), 32'd0);

        // Door pause and resume with a partial tick preserved
        phase = "door_pause";
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        cook_cnt = 0;
        idle(6);  check("remain_before_pause", 32'(remain), 32'd4);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        check("paused_p", 32'(p), 32'd0);
        check("paused_remain", 32'(remain), 32'd4);
        check("start_door_open_ignored", 32'(st), 32'd2);
        idle(1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("resumed", 32'(st), 32'd1);
        idle(1);  check("resume_1", 32'(remain), 32'd4);
        idle(1);  check("resume_2", 32'(remain), 32'd3);
        idle(12); check("pause_done", 32'(st), 32'd3);
        check("pause_cook_cycles", 32'(cook_cnt), 32'd20);

        // Stop on the 2nd beep cycle
        phase = "beep_stop";
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("beep_stop_st", 32'(st), 32'd0);
        check("beep_stop_done", 32'(done), 32'd0);

        // Cancel: stop pauses, second stop cancels
        phase = "cancel";
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("pause_hold", 32'(remain), 32'd6);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("cancel_remain", 32'(remain), 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("start_no_load", 32'(st), 32'd0);

        // Ignored inputs in idle
        phase = "ignored";
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        check("start_door_idle", 32'(p), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
        check("load_wins_remain", 32'(remain), 32'd7);
        check("load_wins_st", 32'(st), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("stop_in_idle", 32'(remain), 32'd7);

        // Reset mid-run and a reset glitch between edges
        phase = "reset_mid";
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("rst_p", 32'(p), 32'd0);
        check("rst_remain", 32'(remain), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(2);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        idle(1);
        check("glitch_ignored", 32'(st), 32'd1);
        check("glitch_remain", 32'(remain), 32'd15);

        // Randomized front-panel activity
        phase = "random";
        for (int i = 0; i < 900; i++) begin
            cyc(logic'($urandom_range(0, 99) != 0),
                logic'($urandom_range(0, 9) == 0),
                logic'($urandom_range(0, 9) < 3),
                logic'($urandom_range(0, 19) == 0),
                logic'($urandom_range(0, 9) < 2),
                TW'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
